// File: rtl/evr_v1_tod_pkg.sv
// Shared constants and types for the EVR time-of-day transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package evr_v1_tod_pkg;

  localparam int SECONDS_W = 32;
  localparam int BIT_CNT_W = 6;
  localparam int GAP_CNT_W = 8;

  // Event codes understood by the receiver's time-of-day decoder
  localparam logic [7:0] EVT_NULL  = 8'h00;
  localparam logic [7:0] TOD_ZERO  = 8'h70;
  localparam logic [7:0] TOD_ONE   = 8'h71;
  localparam logic [7:0] TOD_LATCH = 8'h7D;

  // Index of the final bit of a seconds word
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tod_state_e;

  // Map one seconds bit onto its event code
  function automatic logic [7:0] tod_code(input logic b);
    return b ? TOD_ONE : TOD_ZERO;
  endfunction

endpackage

// File: rtl/evr_v1_tod_shifter.sv
// Seconds shift register, bit counter and inter-bit gap counter.
// Latency: registered; load/advance take effect on the next clock edge.
// Backpressure: none; the owning FSM decides when to advance or count the gap.
//
// Ports:
//   clk, rst        event clock, synchronous active-high reset
//   load, load_val  restart a sequence with a new seconds word (wins over advance)
//   advance         current bit was emitted: shift left, count it, rearm the gap
//   gap_dec         one gap cycle elapsed
//   tod_bit         bit to emit next (MSB of the shift register)
//   done            the bit presented now is the last of the word
//   gap_last        the current gap cycle is the final one
module evr_v1_tod_shifter
  import evr_v1_tod_pkg::*;
#(
  parameter int unsigned BIT_GAP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [SECONDS_W-1:0] load_val,
  input  logic                 advance,
  input  logic                 gap_dec,
  output logic                 tod_bit,
  output logic                 done,
  output logic                 gap_last
);

  localparam logic [GAP_CNT_W-1:0] GAP_INIT = GAP_CNT_W'(BIT_GAP);

  logic [SECONDS_W-1:0] shift_q,   shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (load) begin
      shift_d   = load_val;
      bit_cnt_d = '0;
    end else if (advance) begin
      shift_d   = {shift_q[SECONDS_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
      gap_cnt_d = GAP_INIT;
    end else if (gap_dec && (gap_cnt_q != '0)) begin
      gap_cnt_d = gap_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign tod_bit  = shift_q[SECONDS_W-1];
  assign done     = (bit_cnt_q == LAST_BIT);
  // A count of 0 can only be seen defensively; treat it as "gap over" too
  assign gap_last = (gap_cnt_q <= GAP_CNT_W'(1));

endmodule

// File: rtl/evr_v1_time_of_day_transmitter.sv
// Merges the 0x7D latch and 32 serialized seconds bits (0x70/0x71) into idle event slots.
// Latency: EventOut registered, one cycle after its input; first bit two cycles after Pps.
// Backpressure: upstream events always win over pending bits; a bit simply waits, never drops.
//
// Ports:
//   Clock, Reset          event clock, synchronous active-high reset
//   Pps                   one-cycle pulse-per-second tick
//   SecondsIn/SecondsLoad software seconds value and its load strobe
//   EventIn               upstream event code, 0x00 = idle slot
//   EventOut              merged event stream (registered)
//   Busy                  a bit sequence is in progress
//   TruncErr              sticky: tick arrived before the previous word finished
//   DropCount             saturating count of upstream events overwritten by 0x7D
// Build option: EVR_TOD_AUTOINC_EN makes NextSeconds advance by one on every
// tick that does not coincide with a software load.
module evr_v1_time_of_day_transmitter
  import evr_v1_tod_pkg::*;
#(
  parameter int unsigned BIT_GAP = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Pps,
  input  logic [SECONDS_W-1:0] SecondsIn,
  input  logic                 SecondsLoad,
  input  logic [7:0]           EventIn,
  output logic [7:0]           EventOut,
  output logic                 Busy,
  output logic                 TruncErr,
  output logic [15:0]          DropCount
);

  tod_state_e           state_q,     state_d;
  logic [7:0]           event_out_q, event_out_d;
  logic                 trunc_err_q, trunc_err_d;
  logic [15:0]          drop_cnt_q,  drop_cnt_d;
  logic [SECONDS_W-1:0] next_sec_q,  next_sec_d;

  logic sh_load, sh_advance, sh_gap_dec;
  logic sh_bit, sh_done, sh_gap_last;

  evr_v1_tod_shifter #(
    .BIT_GAP (BIT_GAP)
  ) u_shifter (
    .clk      (Clock),
    .rst      (Reset),
    .load     (sh_load),
    .load_val (next_sec_q),
    .advance  (sh_advance),
    .gap_dec  (sh_gap_dec),
    .tod_bit  (sh_bit),
    .done     (sh_done),
    .gap_last (sh_gap_last)
  );

  // FSM and output-slot arbitration: tick > upstream event > pending bit > idle
  always_comb begin
    state_d     = state_q;
    event_out_d = EVT_NULL;
    trunc_err_d = trunc_err_q;
    drop_cnt_d  = drop_cnt_q;
    sh_load     = 1'b0;
    sh_advance  = 1'b0;
    sh_gap_dec  = 1'b0;

    if (Pps) begin
      event_out_d = TOD_LATCH;
      sh_load     = 1'b1;
      state_d     = ST_SEND;
      if (state_q != ST_IDLE) begin
        trunc_err_d = 1'b1;
      end
      if ((EventIn != EVT_NULL) && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else begin
      if (EventIn != EVT_NULL) begin
        event_out_d = EventIn;
      end
      case (state_q)
        ST_SEND: begin
          if (EventIn == EVT_NULL) begin
            event_out_d = tod_code(sh_bit);
            sh_advance  = 1'b1;
            if (sh_done) begin
              state_d = ST_IDLE;
            end else if (BIT_GAP > 0) begin
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // The gap runs on wall-clock cycles, so passing upstream traffic eats into it
          sh_gap_dec = 1'b1;
          if (sh_gap_last) begin
            state_d = ST_SEND;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A same-cycle load wins; the tick still shifts the old value via load_val
  always_comb begin
    next_sec_d = next_sec_q;
    if (SecondsLoad) begin
      next_sec_d = SecondsIn;
    end
`ifdef EVR_TOD_AUTOINC_EN
    else if (Pps) begin
      next_sec_d = next_sec_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      event_out_q <= EVT_NULL;
      trunc_err_q <= 1'b0;
      drop_cnt_q  <= '0;
      next_sec_q  <= '0;
    end else begin
      state_q     <= state_d;
      event_out_q <= event_out_d;
      trunc_err_q <= trunc_err_d;
      drop_cnt_q  <= drop_cnt_d;
      next_sec_q  <= next_sec_d;
    end
  end

  assign EventOut  = event_out_q;
  assign Busy      = (state_q != ST_IDLE);
  assign TruncErr  = trunc_err_q;
  assign DropCount = drop_cnt_q;

endmodule
